// File: rtl/pulse_frame_rx_if.sv
// Frame output bus of the pulse-width frame receiver: held frame, status and ack.
// The receiver drives it through the master modport; the consumer uses the slave modport.
interface pulse_frame_rx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     frame_ack;
    logic [DEPTH*WIDTH-1:0]   frame_data;
    logic [CW-1:0]            frame_count;
    logic                     frame_valid;
    logic [1:0]               frame_err;
    logic                     frame_drop;

    modport master (
        input  frame_ack,
        output frame_data, frame_count, frame_valid, frame_err, frame_drop
    );

    modport slave (
        output frame_ack,
        input  frame_data, frame_count, frame_valid, frame_err, frame_drop
    );
endinterface

// File: rtl/pulse_frame_rx.sv
// Pulse-width frame receiver: measures high pulses on a serial line, groups them
// into frames separated by long low gaps, and hands frames out via valid/ack.
module pulse_frame_rx #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int THRESHOLD = 8,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    pulse_frame_rx_if.master  fr,
    output logic              busy
);
    typedef enum logic {IDLE, RX} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] THR     = WIDTH'(THRESHOLD);
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);

    state_t                 state, state_next;
    logic                   prev;
    logic [WIDTH-1:0]       cnt;
    logic [DEPTH*WIDTH-1:0] cap_data;
    logic [CW-1:0]          cap_count;
    logic                   cap_ovf, cap_sat;
    logic                   rise, fall, start, store, done;

    assign rise = in & ~prev;
    assign fall = ~in & prev;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // prev resets high so a line already high at reset release is never taken as a rise
    always_comb begin
        state_next = state;
        start      = 1'b0;
        store      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = RX;
                    start      = 1'b1;
                end
            end
            RX: begin
                if (fall) store = 1'b1;
                if (!prev && !in && cnt == THR) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
            cnt  <= '0;
        end else begin
            prev <= in;
            if (rise || fall)        cnt <= WIDTH'(1);
            else if (cnt != CNT_MAX) cnt <= cnt + WIDTH'(1);
        end
    end

    // On a fall, cnt holds the width of the high run that just ended
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cap_data  <= '0;
            cap_count <= '0;
            cap_ovf   <= 1'b0;
            cap_sat   <= 1'b0;
        end else if (store) begin
            if (cap_count < FULL) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (cap_count == CW'(k)) cap_data[k*WIDTH +: WIDTH] <= cnt;
                end
                cap_count <= cap_count + CW'(1);
            end else begin
                cap_ovf <= 1'b1;
            end
            if (cnt == CNT_MAX) cap_sat <= 1'b1;
        end
    end

    // A commit coinciding with ack replaces the held frame instead of clearing valid
    always_ff @(posedge clk) begin
        if (rst) begin
            fr.frame_data  <= '0;
            fr.frame_count <= '0;
            fr.frame_valid <= 1'b0;
            fr.frame_err   <= '0;
            fr.frame_drop  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            fr.frame_drop <= 1'b0;
            busy          <= (state_next == RX);
            if (done) begin
                if (!fr.frame_valid || fr.frame_ack) begin
                    fr.frame_data  <= cap_data;
                    fr.frame_count <= cap_count;
                    fr.frame_err   <= {cap_sat, cap_ovf};
                    fr.frame_valid <= 1'b1;
                end else begin
                    fr.frame_drop <= 1'b1;
                end
            end else if (fr.frame_valid && fr.frame_ack) begin
                fr.frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pulse_frame_rx.md
Name: pulse_frame_rx

Overview:
- Parametrised successor to the fixed 4-symbol pulse-width deserializer.
- Measures each high pulse on a serial line in clock cycles and buffers up to DEPTH widths as a frame.
- A frame ends when the line stays low for more than THRESHOLD cycles; the frame then goes to an output register with a valid/ack handshake.
- Sits between the raw serial input pin and downstream consumers.

Parameters:
- WIDTH, 8: bits per measured pulse width; the run counter saturates at 2^WIDTH-1.
- DEPTH, 4: maximum pulses stored per frame (DEPTH >= 1).
- THRESHOLD, 8: a low gap of THRESHOLD+1 or more cycles ends the frame (1 <= THRESHOLD < 2^WIDTH-1).
- CW, $clog2(DEPTH+1): derived width of frame_count; not overridden.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in  in  1  serial pulse input, sampled every posedge.
- frame_ack  in  1  consumer accepts the current frame.
- frame_data  out  DEPTH*WIDTH  symbol k in bits [k*WIDTH +: WIDTH]; k=0 is the first pulse received; unused slots are 0.
- frame_count  out  CW  number of valid symbols, 1..DEPTH.
- frame_valid  out  1  output frame held and valid.
- frame_err  out  2  bit0 = overflow (more than DEPTH pulses); bit1 = a pulse width saturated.
- frame_drop  out  1  one-cycle pulse: a completed frame was discarded because the output was full.
- busy  out  1  receiver is in state RX.

Behaviour:
- Reset: prev=1, cnt=0, state=IDLE, capture buffer=0, capture count=0, capture errors=0.
- Reset also clears all outputs: frame_data=0, frame_count=0, frame_valid=0, frame_err=0, frame_drop=0, busy=0.
- Reset mid-frame discards the partial frame and any held output frame.
- Edge detect: prev <= in every cycle. Rise = in & ~prev. Fall = ~in & prev.
- Run counter cnt:
  - On any edge, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^WIDTH-1.
  - On the edge cycle, cnt equals the length of the run that just ended.
- IDLE:
  - Falls and high runs are ignored. A high level present at reset release is never measured.
  - Rise -> RX, clearing the capture buffer, count and errors.
- RX, on Fall, the completed pulse width is cnt:
  - If count < DEPTH: store it in slot[count] and increment count.
  - Otherwise set ovf and leave count at DEPTH.
  - If cnt = 2^WIDTH-1, set sat.
- RX, Rise after a gap of at most THRESHOLD cycles: continue the frame with no action.
- RX timeout: when prev=0, in=0 and cnt=THRESHOLD (i.e. THRESHOLD+1 low samples), the frame completes on that edge and the state returns to IDLE.
- A long high pulse never ends a frame; it saturates and sets sat on its Fall.
- Frame completion commit:
  - If frame_valid=0, or frame_ack=1 on the same edge: load frame_data, frame_count and frame_err = {sat, ovf}; frame_valid=1 from the next cycle.
  - Otherwise: the new frame is discarded, frame_drop=1 for one cycle, and the held frame is unchanged.
- Handshake:
  - frame_ack sampled with frame_valid=1 and no simultaneous commit clears frame_valid on that edge. frame_data/count/err keep their values until the next load.
  - frame_ack with frame_valid=0 is ignored.
  - Outputs stay stable while frame_valid=1.
- Latency: frame_valid rises 1 cycle after the edge at which the (THRESHOLD+1)th low sample is taken.
- busy = (state == RX), registered.
- The receiver accepts a new frame while the output is held; no input back-pressure.

Test Plan:
- Reset, in=0, then high 3 cycles, low 4, high 5, low 12 (DEPTH=4, THRESHOLD=8) -> frame_valid=1, frame_count=2, frame_data slot0=3, slot1=5, slots2-3=0, frame_err=00; ack clears frame_valid next cycle.
- Gap boundary: pulses of 2 and 2 separated by exactly 8 low cycles -> one frame, count=2. The same pulses separated by 9 low cycles -> two frames: first count=1, the second committed only after ack.
- Overflow: 6 pulses of widths 1..6 with gaps of 2 -> count=4, slots={1,2,3,4}, frame_err=01.
- Saturation: high for 300 cycles then long low, WIDTH=8 -> slot0=255, frame_err=10.
- Handshake: two complete frames with no ack -> first held unchanged, frame_drop pulses once. Ack asserted on the commit edge of a frame -> new frame loaded and frame_valid stays 1.
- Reset: assert rst during RX after 2 pulses -> all outputs 0, IDLE. in held high at reset release, then low 10 -> no frame produced.
